conv_waddr_gen: RTL and testbench
=================================

# conv_waddr_gen

Write-side address generator for convolution outputs. It takes the serial stream of output pixels from the conv datapath and produces the SRAM group B write enables, word address, lane mask and write data. In SRAM group B each word packs four output channels, and the four banks are interleaved by pixel row/column parity, so the next layer's read-address generator can fetch any 2x2 neighbourhood in one cycle. It sits beside the read-address generator and is sequenced by the same top-level `state` code (3 = conv layer 1, 6x6 output; 4 = conv layer 2, 5x5 output).

## Interface
Parameters:
- `DW`, default 8: bit width of one output pixel (one channel lane).
- `CH_L1`, default 8: number of output channels in the state-3 layer, range 1..28.
- `CH_L2`, default 8: number of output channels in the state-4 layer, range 1..28.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `state`, in, 4: top-level phase code. 3 = layer 1 (6x6), 4 = layer 2 (5x5), any other value = idle.
- `data_valid`, in, 1: `data_in` carries the next output pixel this cycle.
- `data_in`, in, DW: pixel value, already quantized.
- `sram_wen_b0`..`sram_wen_b3`, out, 1 each: active-low write enable for banks B0..B3.
- `sram_waddr_b`, out, 6: write word address, shared by all four banks.
- `sram_wordmask_b`, out, 4: active-low lane mask. Bit i enables channel lane i.
- `sram_wdata_b`, out, 4*DW: `data_in` replicated into all four lanes.
- `layer_done`, out, 1: one-cycle pulse issued with the final write of a layer.

## Operation
FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when `state` is 3 or 4.
  - Latch layer dimensions: DIM = 6 and CH = CH_L1 for state 3; DIM = 5 and CH = CH_L2 for state 4.
  - Clear all counters.
- RUN: each `data_valid` pixel advances the col/row/ch counters.
  - col wraps at DIM-1 and increments row.
  - row wraps at DIM-1 and increments ch.
  - The pixel at col = row = DIM-1 and ch = CH-1 is the last one: issue the write with `layer_done`, then go to DONE.
- DONE: `data_valid` is ignored.
  - Go to IDLE when `state` is neither 3 nor 4.
  - If `state` changes directly to the other layer code, restart in RUN with the new dimensions and cleared counters.
- Layer change inside RUN: if `state` changes value (3 <-> 4), abandon the current layer and restart as above. If `state` leaves {3,4}, go to IDLE and drop any partial layer. A pixel presented in that same cycle is not written.
- Pixel order is fixed: channel-major, then raster within a channel (row-major, col fastest).

Write mapping for the pixel at (row r, col c, channel k):
- Bank index = 2*r[0] + c[0]. Only that bank's `sram_wen_bX` goes to 0.
- Address = (r>>1)*3 + (c>>1) + (k>>2)*9.
  - Both layers use a 3x3 word block per channel group.
  - Compute in 7 bits internally; truncate to 6 bits for the output.
  - Maximum address is 62 for CH = 28.
- Lane = k[1:0]. `sram_wordmask_b` = ~(4'b0001 << lane).

Idle outputs:
- `sram_wen_b*` = 1, `sram_wordmask_b` = 4'hF, `sram_waddr_b` = 0, `sram_wdata_b` = 0, `layer_done` = 0.
- Idle outputs apply whenever no write is issued.

## Timing
- All outputs are registered.
- A valid pixel sampled at edge N drives its write signals during the cycle after edge N, for exactly one cycle.
- Back-to-back `data_valid` gives one write per cycle with no bubbles.
- `layer_done` is high in the same cycle as the final write and never in any other cycle.
- Reset: when `rst_n` = 0 is sampled, the next edge forces all outputs to their idle values, the FSM to IDLE and the counters to 0.
  - This takes priority over `data_valid` and `state`.
  - A write already on the outputs completes its cycle; no further writes follow.
- Gaps in `data_valid` hold the counters and keep the idle outputs. The pixel sequence continues exactly where it stopped.
- At most one bank enable is low in any cycle.

## Test plan
- **Reset:** assert `rst_n` = 0 with `state` = 3 and `data_valid` = 1 -> next cycle all `sram_wen_b*` = 1, `sram_wordmask_b` = F, `sram_waddr_b` = 0, `layer_done` = 0.
- **Layer 1 channel 0:** `state` = 3, 36 consecutive valids with `data_in` = pixel index.
  - (0,0) writes B0, address 0, mask E, one cycle after its valid.
  - (0,1) writes B1, address 0.
  - (1,0) writes B2, address 0.
  - (5,5) writes B3, address 8.
  - `sram_wdata_b` = data replicated into all four lanes.
- **Channel packing:** layer 1, channel 5, pixel (2,3) -> B1, address 13, mask D. Channel 4, pixel (0,0) -> B0, address 9, mask E.
- **Layer end:** `CH_L1` = 8, 288 valids with random 0-3 cycle gaps.
  - `layer_done` pulses once, with the write of (5,5,7) at B3, address 17, mask 7.
  - A 289th valid produces no write.
- **Layer 2:** `state` = 4, `CH_L2` = 8.
  - Pixel (4,4) ch0 -> B0, address 8.
  - Row wraps after col 4; channel wraps after 25 pixels.
  - (4,4,7) -> B0, address 17, mask 7, with `layer_done` = 1.
- **Mid-layer abort:** after 10 valids in `state` 3, set `state` = 4 and continue the valids.
  - The first write lands at (0,0,0): B0, address 0.
  - Repeat with `state` = 0: no writes occur until `state` returns to 3 or 4.

Source files
------------

// File: rtl/conv_waddr_gen.sv
// conv_waddr_gen: SRAM group B write-side address generator for conv outputs.
// Each pixel of the channel-major, raster-ordered stream is written into the
// bank selected by its row/col parity. The word address selects the 2x2 tile
// and the channel group, and the lane mask selects the channel within the word.
module conv_waddr_gen #(
    parameter int DW    = 8,
    parameter int CH_L1 = 8,
    parameter int CH_L2 = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      state,
    input  logic            data_valid,
    input  logic [DW-1:0]   data_in,
    output logic            sram_wen_b0,
    output logic            sram_wen_b1,
    output logic            sram_wen_b2,
    output logic            sram_wen_b3,
    output logic [5:0]      sram_waddr_b,
    output logic [3:0]      sram_wordmask_b,
    output logic [4*DW-1:0] sram_wdata_b,
    output logic            layer_done
);

    localparam logic [4:0] CH1_M1 = 5'(CH_L1 - 1);
    localparam logic [4:0] CH2_M1 = 5'(CH_L2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    fsm_t            fsm_r;
    logic [3:0]      code_r;      // layer code currently being written
    logic [2:0]      dim_m1_r;    // DIM-1 of the current layer
    logic [4:0]      ch_m1_r;     // CH-1 of the current layer
    logic [2:0]      col_r;
    logic [2:0]      row_r;
    logic [4:0]      ch_r;
    logic [3:0]      wen_r;
    logic [5:0]      waddr_r;
    logic [3:0]      mask_r;
    logic [4*DW-1:0] wdata_r;
    logic            done_r;

    // True for the two phase codes this block writes outputs for.
    function automatic logic is_layer_code(input logic [3:0] s);
        return (s == 4'd3) || (s == 4'd4);
    endfunction

    // Output side length minus one: 6x6 for layer 1, 5x5 for layer 2.
    function automatic logic [2:0] layer_dim_m1(input logic [3:0] s);
        return (s == 4'd3) ? 3'd5 : 3'd4;
    endfunction

    // Channel count minus one for the selected layer.
    function automatic logic [4:0] layer_ch_m1(input logic [3:0] s);
        return (s == 4'd3) ? CH1_M1 : CH2_M1;
    endfunction

    // Word address: 3x3 tile grid per channel group of four, 7-bit arithmetic.
    function automatic logic [5:0] word_addr(input logic [2:0] r,
                                             input logic [2:0] c,
                                             input logic [4:0] k);
        logic [6:0] a;
        a = ({5'd0, r[2:1]} * 7'd3) + {5'd0, c[2:1]} + ({4'd0, k[4:2]} * 7'd9);
        return a[5:0];
    endfunction

    // Active-low one-cold select of a 4-entry field.
    function automatic logic [3:0] one_cold(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Layer sequencing, pixel counters and registered SRAM write outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_r    <= ST_IDLE;
            code_r   <= 4'd0;
            dim_m1_r <= 3'd0;
            ch_m1_r  <= 5'd0;
            col_r    <= 3'd0;
            row_r    <= 3'd0;
            ch_r     <= 5'd0;
            wen_r    <= 4'hF;
            waddr_r  <= 6'd0;
            mask_r   <= 4'hF;
            wdata_r  <= '0;
            done_r   <= 1'b0;
        end else begin
            // No write unless a pixel is accepted below.
            wen_r   <= 4'hF;
            waddr_r <= 6'd0;
            mask_r  <= 4'hF;
            wdata_r <= '0;
            done_r  <= 1'b0;
            case (fsm_r)
                ST_IDLE: begin
                    if (is_layer_code(state)) begin
                        fsm_r    <= ST_RUN;
                        code_r   <= state;
                        dim_m1_r <= layer_dim_m1(state);
                        ch_m1_r  <= layer_ch_m1(state);
                        col_r    <= 3'd0;
                        row_r    <= 3'd0;
                        ch_r     <= 5'd0;
                    end else begin
                        fsm_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!is_layer_code(state)) begin
                        // Partial layer dropped; the pixel of this cycle is not written.
                        fsm_r <= ST_IDLE;
                        col_r <= 3'd0;
                        row_r <= 3'd0;
                        ch_r  <= 5'd0;
                    end else if (state != code_r) begin
                        // Layer switch: restart with the new geometry.
                        fsm_r    <= ST_RUN;
                        code_r   <= state;
                        dim_m1_r <= layer_dim_m1(state);
                        ch_m1_r  <= layer_ch_m1(state);
                        col_r    <= 3'd0;
                        row_r    <= 3'd0;
                        ch_r     <= 5'd0;
                    end else if (data_valid) begin
                        wen_r   <= one_cold({row_r[0], col_r[0]});
                        waddr_r <= word_addr(row_r, col_r, ch_r);
                        mask_r  <= one_cold(ch_r[1:0]);
                        wdata_r <= {4{data_in}};
                        if (col_r == dim_m1_r) begin
                            col_r <= 3'd0;
                            if (row_r == dim_m1_r) begin
                                row_r <= 3'd0;
                                ch_r  <= ch_r + 5'd1;
                            end else begin
                                row_r <= row_r + 3'd1;
                            end
                        end else begin
                            col_r <= col_r + 3'd1;
                        end
                        if ((col_r == dim_m1_r) && (row_r == dim_m1_r) && (ch_r == ch_m1_r)) begin
                            done_r <= 1'b1;
                            fsm_r  <= ST_DONE;
                        end else begin
                            fsm_r <= ST_RUN;
                        end
                    end else begin
                        fsm_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (!is_layer_code(state)) begin
                        fsm_r <= ST_IDLE;
                    end else if (state != code_r) begin
                        fsm_r    <= ST_RUN;
                        code_r   <= state;
                        dim_m1_r <= layer_dim_m1(state);
                        ch_m1_r  <= layer_ch_m1(state);
                        col_r    <= 3'd0;
                        row_r    <= 3'd0;
                        ch_r     <= 5'd0;
                    end else begin
                        fsm_r <= ST_DONE;
                    end
                end
                default: begin
                    fsm_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sram_wen_b0     = wen_r[0];
    assign sram_wen_b1     = wen_r[1];
    assign sram_wen_b2     = wen_r[2];
    assign sram_wen_b3     = wen_r[3];
    assign sram_waddr_b    = waddr_r;
    assign sram_wordmask_b = mask_r;
    assign sram_wdata_b    = wdata_r;
    assign layer_done      = done_r;

endmodule

// File: tb/tb_conv_waddr_gen.sv
// Scoreboard bench for conv_waddr_gen: the driver pushes the expected write of
// every accepted pixel, a negedge monitor pops and compares each write, checks
// idle outputs otherwise, and cross-checks hand-computed spot pixels.
module tb_conv_waddr_gen;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      state;
    logic            data_valid;
    logic [DW-1:0]   data_in;
    logic            sram_wen_b0, sram_wen_b1, sram_wen_b2, sram_wen_b3;
    logic [5:0]      sram_waddr_b;
    logic [3:0]      sram_wordmask_b;
    logic [4*DW-1:0] sram_wdata_b;
    logic            layer_done;

    conv_waddr_gen #(.DW(DW), .CH_L1(8), .CH_L2(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .state           (state),
        .data_valid      (data_valid),
        .data_in         (data_in),
        .sram_wen_b0     (sram_wen_b0),
        .sram_wen_b1     (sram_wen_b1),
        .sram_wen_b2     (sram_wen_b2),
        .sram_wen_b3     (sram_wen_b3),
        .sram_waddr_b    (sram_waddr_b),
        .sram_wordmask_b (sram_wordmask_b),
        .sram_wdata_b    (sram_wdata_b),
        .layer_done      (layer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         layer;
        int         k;
        int         r;
        int         c;
        logic [3:0] wen;
        logic [5:0] addr;
        logic [3:0] mask;
        logic [31:0] data;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t spots[11];
    int   spot_hit[11];

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;

    // bench-side model of the pixel sequence
    int m_col, m_row, m_ch, m_dim, m_chn, m_layer;
    bit m_run = 1'b0;

    exp_t       mon_e;
    logic [3:0] mon_wen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t spot(input int layer, input int k, input int r, input int c,
                                  input logic [3:0] wen, input logic [5:0] addr,
                                  input logic [3:0] mask, input logic done);
        exp_t s;
        s.layer = layer; s.k = k; s.r = r; s.c = c;
        s.wen = wen; s.addr = addr; s.mask = mask; s.data = 32'd0; s.done = done;
        return s;
    endfunction

    // state change: model restarts or stops; a pixel offered this cycle is dropped
    task automatic set_state(input logic [3:0] s, input logic v);
        state      = s;
        data_valid = v;
        data_in    = 8'hEE;
        tick();
        data_valid = 1'b0;
        if (s == 4'd3 || s == 4'd4) begin
            m_run = 1'b1; m_layer = int'(s);
            m_dim = (s == 4'd3) ? 6 : 5;
            m_chn = 8;
            m_col = 0; m_row = 0; m_ch = 0;
        end else begin
            m_run = 1'b0;
        end
    endtask

    task automatic pixel(input logic [7:0] d);
        exp_t e;
        bit   last;
        data_valid = 1'b1;
        data_in    = d;
        if (m_run) begin
            last = (m_col == m_dim - 1) && (m_row == m_dim - 1) && (m_ch == m_chn - 1);
            e.layer = m_layer; e.k = m_ch; e.r = m_row; e.c = m_col;
            e.wen  = 4'hF & ~(4'b0001 << ((m_row % 2) * 2 + (m_col % 2)));
            e.addr = 6'((m_row / 2) * 3 + (m_col / 2) + (m_ch / 4) * 9);
            e.mask = 4'hF & ~(4'b0001 << (m_ch % 4));
            e.data = {4{d}};
            e.done = last;
            exp_q.push_back(e);
            if (m_col == m_dim - 1) begin
                m_col = 0;
                if (m_row == m_dim - 1) begin
                    m_row = 0; m_ch++;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
            if (last) m_run = 1'b0;
        end
        tick();
        data_valid = 1'b0;
    endtask

    // monitor: compare each write against the scoreboard, idle values otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            mon_wen = {sram_wen_b3, sram_wen_b2, sram_wen_b1, sram_wen_b0};
            if (mon_wen != 4'hF) begin
                chk("one_bank_low", 64'($countones(~mon_wen)), 64'd1);
                chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("wen L%0d k%0d r%0d c%0d", mon_e.layer, mon_e.k, mon_e.r, mon_e.c),
                        64'(mon_wen), 64'(mon_e.wen));
                    chk($sformatf("addr L%0d k%0d r%0d c%0d", mon_e.layer, mon_e.k, mon_e.r, mon_e.c),
                        64'(sram_waddr_b), 64'(mon_e.addr));
                    chk($sformatf("mask L%0d k%0d r%0d c%0d", mon_e.layer, mon_e.k, mon_e.r, mon_e.c),
                        64'(sram_wordmask_b), 64'(mon_e.mask));
                    chk("wdata", 64'(sram_wdata_b), 64'(mon_e.data));
                    chk($sformatf("done L%0d k%0d r%0d c%0d", mon_e.layer, mon_e.k, mon_e.r, mon_e.c),
                        64'(layer_done), 64'(mon_e.done));
                    for (int i = 0; i < 11; i++) begin
                        if (spots[i].layer == mon_e.layer && spots[i].k == mon_e.k &&
                            spots[i].r == mon_e.r && spots[i].c == mon_e.c) begin
                            spot_hit[i]++;
                            chk($sformatf("spot%0d", i),
                                {50'd0, mon_wen, sram_waddr_b, sram_wordmask_b},
                                {50'd0, spots[i].wen, spots[i].addr, spots[i].mask});
                            chk($sformatf("spot%0d_done", i), 64'(layer_done), 64'(spots[i].done));
                        end
                    end
                end
                if (layer_done) done_cnt++;
            end else begin
                chk("idle_outputs", {21'd0, sram_wordmask_b, sram_waddr_b, sram_wdata_b, layer_done},
                    {21'd0, 4'hF, 6'd0, 32'd0, 1'b0});
            end
        end
    end

    initial begin
        spots[0]  = spot(3, 0, 0, 0, 4'hE, 6'd0,  4'hE, 1'b0);
        spots[1]  = spot(3, 0, 0, 1, 4'hD, 6'd0,  4'hE, 1'b0);
        spots[2]  = spot(3, 0, 1, 0, 4'hB, 6'd0,  4'hE, 1'b0);
        spots[3]  = spot(3, 0, 5, 5, 4'h7, 6'd8,  4'hE, 1'b0);
        spots[4]  = spot(3, 5, 2, 3, 4'hD, 6'd13, 4'hD, 1'b0);
        spots[5]  = spot(3, 4, 0, 0, 4'hE, 6'd9,  4'hE, 1'b0);
        spots[6]  = spot(3, 7, 5, 5, 4'h7, 6'd17, 4'h7, 1'b1);
        spots[7]  = spot(4, 0, 4, 4, 4'hE, 6'd8,  4'hE, 1'b0);
        spots[8]  = spot(4, 0, 1, 0, 4'hB, 6'd0,  4'hE, 1'b0);
        spots[9]  = spot(4, 1, 0, 0, 4'hE, 6'd0,  4'hD, 1'b0);
        spots[10] = spot(4, 7, 4, 4, 4'hE, 6'd17, 4'h7, 1'b1);
        for (int i = 0; i < 11; i++) spot_hit[i] = 0;

        // reset has priority over state and data_valid
        rst_n = 1'b0; state = 4'd3; data_valid = 1'b1; data_in = 8'h55;
        @(posedge clk);
        @(negedge clk);
        chk("rst_wen", 64'({sram_wen_b3, sram_wen_b2, sram_wen_b1, sram_wen_b0}), 64'hF);
        chk("rst_mask", 64'(sram_wordmask_b), 64'hF);
        chk("rst_addr", 64'(sram_waddr_b), 64'd0);
        chk("rst_wdata", 64'(sram_wdata_b), 64'd0);
        chk("rst_done", 64'(layer_done), 64'd0);
        tick();
        rst_n = 1'b1; state = 4'd0; data_valid = 1'b0;
        mon_en = 1'b1;
        tick();

        // layer 1: channel 0 back-to-back, then the rest with 0-3 cycle gaps
        set_state(4'd3, 1'b0);
        for (int p = 0; p < 36; p++) pixel(8'(p));
        for (int p = 36; p < 288; p++) begin
            pixel(8'(p));
            repeat ($urandom_range(3, 0)) tick();
        end
        pixel(8'hAA);            // 289th valid: no write
        repeat (2) tick();

        // layer 2
        set_state(4'd0, 1'b0);
        set_state(4'd4, 1'b0);
        for (int p = 0; p < 200; p++) begin
            pixel(8'(p * 3 + 1));
            if (p % 7 == 3) tick();
        end
        pixel(8'hBB);
        repeat (2) tick();

        // mid-layer abort by switching layer
        set_state(4'd0, 1'b0);
        set_state(4'd3, 1'b0);
        for (int p = 0; p < 10; p++) pixel(8'(p + 100));
        set_state(4'd4, 1'b1);
        for (int p = 0; p < 5; p++) pixel(8'(p + 150));
        // abort to idle; valids while idle write nothing
        set_state(4'd0, 1'b1);
        for (int p = 0; p < 3; p++) pixel(8'(p + 200));
        set_state(4'd3, 1'b1);
        for (int p = 0; p < 4; p++) pixel(8'(p + 210));

        // reset while a write is on the outputs, then resume from a fresh layer
        pixel(8'h77);
        rst_n = 1'b0; data_valid = 1'b1; data_in = 8'h66;
        tick();
        m_run = 1'b0;
        rst_n = 1'b1; data_valid = 1'b0;
        set_state(4'd3, 1'b0);
        pixel(8'h01);
        pixel(8'h02);
        repeat (4) tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'd2);
        for (int i = 0; i < 11; i++) chk($sformatf("spot%0d_hit", i), 64'(spot_hit[i] != 0), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
